mpu_load_sched: RTL and testbench

- Round-robin scheduler that shares the single matrix load unit between NREQ requesters (host DMA, result writeback, test port).
- Grants one requester at a time and forwards its descriptor (dims, register address) to the load unit.
- Muxes the granted requester's element stream into the load unit and tracks ack-driven streaming to completion.
- Reports per-requester done/error pulses. Sits between the requesters and the load unit's en/ack interface.

---
 rtl/mpu_load_sched_pkg.sv | 17 +
 rtl/mpu_load_sched_rr_arbiter.sv | 36 +++
 rtl/mpu_load_sched.sv | 172 +++++++++++++++++
 tb/tb_mpu_load_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_load_sched_pkg.sv
// Shared types and default sizing for the matrix load scheduler.
// Default NREQ and the global matrix geometry live here.
package mpu_load_sched_pkg;

  localparam int NREQ_DEF  = 2;
  localparam int MBITS_DEF = 3;
  localparam int NBITS_DEF = 3;
  localparam int MRS_DEF   = 4;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_STREAM,
    SCHED_DONE
  } sched_state_t;

endpackage

// File: rtl/mpu_load_sched_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr,
// wrapping, returned as one-hot grant plus binary index.
module mpu_load_sched_rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ))
        w_sum = w_sum - (IW+1)'(NREQ);
      w_j = w_sum[IW-1:0];
      if (!o_any && i_valid[w_j]) begin
        o_any      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/mpu_load_sched.sv
// Round-robin owner of the matrix load unit across NREQ requesters.
// Optional ISSUE watchdog: define MPU_LOAD_SCHED_TIMEOUT_EN.
module mpu_load_sched
  import mpu_load_sched_pkg::*;
#(
  parameter int NREQ            = NREQ_DEF,
  parameter int FP              = 32,
  parameter int MBITS           = MBITS_DEF,
  parameter int NBITS           = NBITS_DEF,
  parameter int MATRIX_REG_SIZE = MRS_DEF
`ifdef MPU_LOAD_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT         = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*(MBITS+1)-1:0]     req_m_size,
  input  logic [NREQ*(NBITS+1)-1:0]     req_n_size,
  input  logic [NREQ*MATRIX_REG_SIZE-1:0] req_addr,
  input  logic [NREQ*FP-1:0]            req_element,
  output logic [NREQ-1:0]               req_grant,
  output logic [NREQ-1:0]               req_take,
  output logic [NREQ-1:0]               req_done,
  output logic [NREQ-1:0]               req_error,
  output logic                          load_en,
  output logic [MBITS:0]                load_m_size,
  output logic [NBITS:0]                load_n_size,
  output logic [MATRIX_REG_SIZE-1:0]    load_addr,
  output logic [FP-1:0]                 load_element,
  input  logic                          load_ack,
  input  logic                          load_error,
  output logic                          busy
);

  localparam int MW = MBITS + 1;
  localparam int NW = NBITS + 1;
  localparam int CW = MBITS + NBITS + 2;
  localparam int IW = $clog2(NREQ);

  sched_state_t          r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_gidx;
  logic [NREQ-1:0]       r_grant;
  logic [NREQ-1:0]       r_done;
  logic [NREQ-1:0]       r_err;
  logic                  r_load_en;
  logic [MW-1:0]         r_m;
  logic [NW-1:0]         r_n;
  logic [MATRIX_REG_SIZE-1:0] r_addr;
  logic [CW-1:0]         r_cnt;

  logic [NREQ-1:0]       w_arb_grant;
  logic [IW-1:0]         w_arb_idx;
  logic                  w_arb_any;
  logic [IW-1:0]         w_next_ptr;
  logic [CW-1:0]         w_prod;
  logic                  w_take;

  mpu_load_sched_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  assign w_next_ptr = (r_gidx == IW'(NREQ-1)) ? '0 : r_gidx + IW'(1);
  // Full-width product so e.g. 15x15 is not truncated to dim width.
  assign w_prod = CW'(r_m) * CW'(r_n);
  assign w_take = load_ack &
                  (((r_state == SCHED_ISSUE) & ~load_error) |
                   (r_state == SCHED_STREAM));

  assign req_grant    = r_grant;
  assign req_take     = w_take ? r_grant : '0;
  assign req_done     = r_done;
  assign req_error    = r_err;
  assign load_en      = r_load_en;
  assign load_m_size  = r_m;
  assign load_n_size  = r_n;
  assign load_addr    = r_addr;
  assign load_element = (|r_grant) ? req_element[r_gidx*FP +: FP] : '0;
  assign busy         = (r_state != SCHED_IDLE);

`ifdef MPU_LOAD_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wd;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SCHED_IDLE;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_load_en <= 1'b0;
      r_m       <= '0;
      r_n       <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
`ifdef MPU_LOAD_SCHED_TIMEOUT_EN
      r_wd      <= '0;
`endif
    end else begin
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        SCHED_IDLE: begin
          if (w_arb_any) begin
            r_grant   <= w_arb_grant;
            r_gidx    <= w_arb_idx;
            r_m       <= req_m_size[w_arb_idx*MW +: MW];
            r_n       <= req_n_size[w_arb_idx*NW +: NW];
            r_addr    <= req_addr[w_arb_idx*MATRIX_REG_SIZE +: MATRIX_REG_SIZE];
            r_load_en <= 1'b1;
            r_state   <= SCHED_ISSUE;
`ifdef MPU_LOAD_SCHED_TIMEOUT_EN
            r_wd      <= '0;
`endif
          end
        end
        SCHED_ISSUE: begin
          if (load_error) begin
            r_err     <= r_grant;
            r_grant   <= '0;
            r_load_en <= 1'b0;
            r_ptr     <= w_next_ptr;
            r_state   <= SCHED_IDLE;
          end else if (load_ack) begin
            r_cnt     <= CW'(1);
            r_load_en <= 1'b0;
            r_state   <= SCHED_STREAM;
          end
`ifdef MPU_LOAD_SCHED_TIMEOUT_EN
          else if (r_wd == WW'(TIMEOUT - 1)) begin
            r_err     <= r_grant;
            r_grant   <= '0;
            r_load_en <= 1'b0;
            r_ptr     <= w_next_ptr;
            r_state   <= SCHED_IDLE;
          end else begin
            r_wd <= r_wd + WW'(1);
          end
`endif
        end
        SCHED_STREAM: begin
          if (load_ack) begin
            if (r_cnt != '1)
              r_cnt <= r_cnt + CW'(1);
          end else begin
            r_state <= SCHED_DONE;
            if (r_cnt == w_prod)
              r_done <= r_grant;
            else
              r_err <= r_grant;
          end
        end
        SCHED_DONE: begin
          r_grant <= '0;
          r_ptr   <= w_next_ptr;
          r_state <= SCHED_IDLE;
        end
        default: r_state <= SCHED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_load_sched.sv
// Table-driven plus randomized transaction bench for mpu_load_sched.
module tb_mpu_load_sched;

  localparam int NR  = 2;
  localparam int FPW = 32;
  localparam int MB  = 3;
  localparam int NB  = 3;
  localparam int MRS = 4;
  localparam int MW  = MB + 1;
  localparam int NW  = NB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*MW-1:0]  req_m_size = '0;
  logic [NR*NW-1:0]  req_n_size = '0;
  logic [NR*MRS-1:0] req_addr = '0;
  logic [NR*FPW-1:0] req_element = '0;
  logic [NR-1:0]     req_grant, req_take, req_done, req_error;
  logic              load_en, load_ack = 1'b0, load_error = 1'b0, busy;
  logic [MW-1:0]     load_m_size;
  logic [NW-1:0]     load_n_size;
  logic [MRS-1:0]    load_addr;
  logic [FPW-1:0]    load_element;

  int checks = 0;
  int errors = 0;
  int mptr = 0;

  mpu_load_sched #(
    .NREQ(NR), .FP(FPW), .MBITS(MB), .NBITS(NB), .MATRIX_REG_SIZE(MRS)
`ifdef MPU_LOAD_SCHED_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_m_size(req_m_size),
    .req_n_size(req_n_size), .req_addr(req_addr),
    .req_element(req_element), .req_grant(req_grant),
    .req_take(req_take), .req_done(req_done), .req_error(req_error),
    .load_en(load_en), .load_m_size(load_m_size),
    .load_n_size(load_n_size), .load_addr(load_addr),
    .load_element(load_element), .load_ack(load_ack),
    .load_error(load_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (!$onehot0(req_grant) || ((req_done & req_error) != '0)) begin
      errors++;
      $display("FAIL grant_pulse_excl: grant=%b done=%b err=%b", req_grant, req_done, req_error);
    end
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int i, input int m, input int n, input int a);
    req_m_size[i*MW +: MW]  = MW'(m);
    req_n_size[i*NW +: NW]  = NW'(n);
    req_addr[i*MRS +: MRS]  = MRS'(a);
  endtask

  // Spec rule: first valid requester at or after the pointer, wrapping.
  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return 0;
  endfunction

  // act < 0: load unit rejects in ISSUE; else number of acked cycles.
  task automatic txn(input logic [NR-1:0] vld, input int act,
                     input int ew, input bit eerr);
    int lat;
    int em, en, ea;
    logic [NR-1:0] oh;
    logic [FPW-1:0] el;
    oh = NR'(1) << ew;
    em = int'(req_m_size[ew*MW +: MW]);
    en = int'(req_n_size[ew*NW +: NW]);
    ea = int'(req_addr[ew*MRS +: MRS]);
    req_valid = vld;
    load_ack = 1'b0;
    load_error = 1'b0;
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (load_en !== 1'b1 && lat < 20);
    chk("issue_latency", 64'(lat), 64'(1));
    if (load_en !== 1'b1) return;
    chk("grant", 64'(req_grant), 64'(oh));
    chk("load_m", 64'(load_m_size), 64'(em));
    chk("load_n", 64'(load_n_size), 64'(en));
    chk("load_addr", 64'(load_addr), 64'(ea));
    chk("busy_issue", 64'(busy), 64'(1));
    el = FPW'($urandom);
    req_element[ew*FPW +: FPW] = el;
    req_valid[ew] = 1'b0;
    set_desc(ew, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    if (act < 0) begin
      load_error = 1'b1;
      load_ack = 1'($urandom_range(0, 1));
      #1;
      chk("take_on_err", 64'(req_take), 64'(0));
      chk("elem_issue", 64'(load_element), 64'(el));
      cyc();
      load_error = 1'b0;
      load_ack = 1'b0;
      #1;
      chk("err_pulse", 64'(req_error), 64'(oh));
      chk("no_done_err", 64'(req_done), 64'(0));
      chk("grant_drop_err", 64'(req_grant), 64'(0));
      chk("busy_idle_err", 64'(busy), 64'(0));
    end else begin
      for (int i = 0; i < act; i++) begin
        if (i > 0) begin
          cyc();
          el = FPW'($urandom);
          req_element[ew*FPW +: FPW] = el;
        end
        load_ack = 1'b1;
        #1;
        chk("take", 64'(req_take), 64'(oh));
        chk("elem", 64'(load_element), 64'(el));
        if (i == 1) chk("load_en_stream", 64'(load_en), 64'(0));
      end
      cyc();
      load_ack = 1'b0;
      #1;
      chk("take_stop", 64'(req_take), 64'(0));
      chk("grant_held", 64'(req_grant), 64'(oh));
      cyc();
      #1;
      chk("done_pulse", 64'(req_done), 64'(eerr ? '0 : oh));
      chk("err_pulse", 64'(req_error), 64'(eerr ? oh : '0));
      cyc();
      #1;
      chk("grant_drop", 64'(req_grant), 64'(0));
      chk("pulse_1cyc_done", 64'(req_done), 64'(0));
      chk("pulse_1cyc_err", 64'(req_error), 64'(0));
      chk("busy_idle", 64'(busy), 64'(0));
    end
    mptr = (ew + 1) % NR;
  endtask

  typedef struct {
    logic [NR-1:0] vld;
    int m0, n0, a0, m1, n1, a1;
    int act;
    int ew;
    bit eerr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int lat;
    int w, m, n, act;
    logic [NR-1:0] v;

    tbl[0] = '{2'b01, 2, 3, 1, 1, 1, 0, 6, 0, 1'b0};
    tbl[1] = '{2'b11, 1, 1, 0, 1, 1, 2, 1, 1, 1'b0};
    tbl[2] = '{2'b11, 1, 1, 3, 1, 1, 2, 1, 0, 1'b0};
    tbl[3] = '{2'b11, 1, 1, 3, 1, 1, 1, 1, 1, 1'b0};
    tbl[4] = '{2'b10, 1, 1, 0, 0, 4, 3, -1, 1, 1'b1};
    tbl[5] = '{2'b11, 2, 2, 2, 1, 1, 1, 3, 0, 1'b1};
    tbl[6] = '{2'b01, 2, 2, 2, 1, 1, 1, 4, 0, 1'b0};
    tbl[7] = '{2'b11, 1, 1, 0, 15, 15, 15, 225, 1, 1'b0};
    tbl[8] = '{2'b11, 3, 1, 4, 1, 1, 0, 4, 0, 1'b1};
    tbl[9] = '{2'b01, 0, 0, 5, 1, 1, 0, 1, 0, 1'b1};

    repeat (2) cyc();
    chk("rst_grant", 64'(req_grant), 64'(0));
    chk("rst_load_en", 64'(load_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_addr", 64'(load_addr), 64'(0));
    chk("rst_elem", 64'(load_element), 64'(0));
    rst = 1'b0;
    #1;

    for (int t = 0; t < 10; t++) begin
      set_desc(0, tbl[t].m0, tbl[t].n0, tbl[t].a0);
      set_desc(1, tbl[t].m1, tbl[t].n1, tbl[t].a1);
      txn(tbl[t].vld, tbl[t].act, tbl[t].ew, tbl[t].eerr);
    end

    // Reset in the middle of a stream, pointer currently at 1.
    set_desc(1, 2, 2, 7);
    req_valid = 2'b10;
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (load_en !== 1'b1 && lat < 20);
    chk("rst_seq_issue", 64'(load_en), 64'(1));
    load_ack = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("abort_grant", 64'(req_grant), 64'(0));
    chk("abort_take", 64'(req_take), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_addr", 64'(load_addr), 64'(0));
    chk("abort_m", 64'(load_m_size), 64'(0));
    chk("abort_elem", 64'(load_element), 64'(0));
    cyc();
    load_ack = 1'b0;
    req_valid = '0;
    cyc();
    rst = 1'b0;
    #1;
    chk("abort_no_done", 64'(req_done), 64'(0));
    chk("abort_no_err", 64'(req_error), 64'(0));
    mptr = 0;
    set_desc(0, 1, 1, 9);
    set_desc(1, 1, 1, 10);
    txn(2'b11, 1, pick(2'b11, mptr), 1'b0);

`ifdef MPU_LOAD_SCHED_TIMEOUT_EN
    set_desc(0, 1, 1, 1);
    req_valid = 2'b01;
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (load_en !== 1'b1 && lat < 20);
    chk("wd_issue", 64'(load_en), 64'(1));
    req_valid = '0;
    lat = 0;
    do begin
      cyc();
      lat++;
      #1;
    end while (req_error[0] !== 1'b1 && lat < 20);
    chk("wd_cycles", 64'(lat), 64'(8));
    chk("wd_grant", 64'(req_grant), 64'(0));
    chk("wd_load_en", 64'(load_en), 64'(0));
    mptr = 1;
`endif

    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < NR; i++)
        set_desc(i, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
      v = NR'($urandom_range(1, (1 << NR) - 1));
      w = pick(v, mptr);
      m = int'(req_m_size[w*MW +: MW]);
      n = int'(req_n_size[w*NW +: NW]);
      if ($urandom_range(0, 5) == 0) act = -1;
      else begin
        act = m * n + $urandom_range(0, 2) - 1;
        if (act < 1) act = 1;
      end
      txn(v, act, w, (act < 0) || (act != m * n));
    end

    req_valid = '0;
    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
